riscv_test_monitor: RTL and testbench

Synthesizable, parametrised pass/fail monitor for the RV32I core and the next generation of our program-check bench logic. It snoops the core's writeback and store buses and keeps a shadow register file. It detects program end through a store to a tohost address or a cycle timeout, then checks a loadable table of up to NUM_CHECKS expected register values. Results are reported on done/pass outputs, so the same block serves both simulation and FPGA bring-up.

---
 rtl/riscv_test_monitor.sv | 257 +++++++++++++++++++++++++
 tb/tb_riscv_test_monitor.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_test_monitor.sv
// -----------------------------------------------------------------------------
// riscv_test_monitor
//
// Pass/fail monitor for an RV32I core. It snoops the writeback and store buses
// into a shadow register file. It detects program end through a store to
// TOHOST_ADDR or through a RUN-cycle timeout. It then walks a loadable table of
// expected register values, one entry per cycle, and reports the verdict.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               pulse; begins a run (accepted in IDLE or DONE only)
//   wb_valid/rd/data    core writeback bus
//   st_valid/addr/data  core store bus
//   chk_we/idx/en/reg/val  table write port (IDLE/DONE only)
//   busy                RUN or CHECK
//   done                DONE (level)
//   pass                verdict, valid while done
//   fail_code           0 none, 1 timeout, 2 tohost code != 1, 3 reg mismatch
//   fail_idx            first mismatching table entry
//   halt_code           st_data of the tohost store
//   cycle_count         RUN cycles elapsed (saturating)
//   retire_count        writebacks seen in RUN (saturating)
// -----------------------------------------------------------------------------
module riscv_test_monitor #(
    parameter int                XLEN           = 32,
    parameter int                NUM_CHECKS     = 4,
    parameter int                TIMEOUT_CYCLES = 200,
    parameter int                CNT_W          = 32,
    parameter logic [XLEN-1:0]   TOHOST_ADDR    = XLEN'(32'h0000_0FFC),
    localparam int               IDX_W          = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             st_valid,
    input  logic [XLEN-1:0]  st_addr,
    input  logic [XLEN-1:0]  st_data,
    input  logic             chk_we,
    input  logic [IDX_W-1:0] chk_idx,
    input  logic             chk_en,
    input  logic [4:0]       chk_reg,
    input  logic [XLEN-1:0]  chk_val,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [1:0]       fail_code,
    output logic [IDX_W-1:0] fail_idx,
    output logic [XLEN-1:0]  halt_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retire_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHECKS - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [XLEN-1:0]        shadow_q [32];
    logic [XLEN-1:0]        shadow_d [32];
    logic [NUM_CHECKS-1:0]  tbl_en_q, tbl_en_d;
    logic [4:0]             tbl_reg_q [NUM_CHECKS];
    logic [4:0]             tbl_reg_d [NUM_CHECKS];
    logic [XLEN-1:0]        tbl_val_q [NUM_CHECKS];
    logic [XLEN-1:0]        tbl_val_d [NUM_CHECKS];
    logic [IDX_W-1:0]       chk_ptr_q, chk_ptr_d;
    logic                   mismatch_q, mismatch_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   pass_q, pass_d;
    logic [1:0]             fail_code_q, fail_code_d;
    logic [IDX_W-1:0]       fail_idx_q, fail_idx_d;
    logic [XLEN-1:0]        halt_code_q, halt_code_d;
    logic [CNT_W-1:0]       cycle_q, cycle_d;
    logic [CNT_W-1:0]       retire_q, retire_d;
    logic                   cur_mis_s;
    logic                   tohost_s;

    // Saturating increment shared by both counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    // Mismatch of the table entry currently under evaluation; x0 is never
    // written so shadow_q[0] always reads zero.
    always_comb begin
        cur_mis_s = tbl_en_q[chk_ptr_q] &&
                    (shadow_q[tbl_reg_q[chk_ptr_q]] != tbl_val_q[chk_ptr_q]);
        tohost_s  = st_valid && (st_addr == TOHOST_ADDR);
    end

    // Next-state and datapath logic for the whole monitor.
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        tbl_en_d    = tbl_en_q;
        tbl_reg_d   = tbl_reg_q;
        tbl_val_d   = tbl_val_q;
        chk_ptr_d   = chk_ptr_q;
        mismatch_d  = mismatch_q;
        pass_d      = pass_q;
        fail_code_d = fail_code_q;
        fail_idx_d  = fail_idx_q;
        halt_code_d = halt_code_q;
        cycle_d     = cycle_q;
        retire_d    = retire_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                // Out-of-range indices match no entry and are dropped.
                for (int i = 0; i < NUM_CHECKS; i++) begin
                    if (chk_we && (chk_idx == IDX_W'(i))) begin
                        tbl_en_d[i]  = chk_en;
                        tbl_reg_d[i] = chk_reg;
                        tbl_val_d[i] = chk_val;
                    end else begin
                        tbl_en_d[i]  = tbl_en_q[i];
                    end
                end
                if (start) begin
                    state_d     = S_RUN;
                    for (int r = 0; r < 32; r++) begin
                        shadow_d[r] = {XLEN{1'b0}};
                    end
                    chk_ptr_d   = {IDX_W{1'b0}};
                    mismatch_d  = 1'b0;
                    pass_d      = 1'b0;
                    fail_code_d = 2'd0;
                    fail_idx_d  = {IDX_W{1'b0}};
                    halt_code_d = {XLEN{1'b0}};
                    cycle_d     = {CNT_W{1'b0}};
                    retire_d    = {CNT_W{1'b0}};
                end else begin
                    state_d     = state_q;
                end
            end
            S_RUN: begin
                cycle_d = sat_inc(cycle_q);
                if (wb_valid) begin
                    retire_d = sat_inc(retire_q);
                    if (wb_rd != 5'd0) begin
                        shadow_d[wb_rd] = wb_data;
                    end else begin
                        shadow_d[0] = {XLEN{1'b0}};
                    end
                end else begin
                    retire_d = retire_q;
                end
                // The tohost store takes precedence over a coincident timeout.
                if (tohost_s) begin
                    state_d     = S_CHECK;
                    halt_code_d = st_data;
                    fail_code_d = (st_data == XLEN'(1)) ? 2'd0 : 2'd2;
                    chk_ptr_d   = {IDX_W{1'b0}};
                end else if (cycle_q >= TMO_LAST) begin
                    state_d     = S_CHECK;
                    fail_code_d = 2'd1;
                    chk_ptr_d   = {IDX_W{1'b0}};
                end else begin
                    state_d     = S_RUN;
                end
            end
            S_CHECK: begin
                if (cur_mis_s && !mismatch_q) begin
                    mismatch_d = 1'b1;
                    fail_idx_d = chk_ptr_q;
                end else begin
                    mismatch_d = mismatch_q;
                end
                if (chk_ptr_q == LAST_IDX) begin
                    state_d = S_DONE;
                    // Timeout and tohost codes were set at termination and outrank a mismatch.
                    if ((fail_code_q == 2'd0) && (mismatch_q || cur_mis_s)) begin
                        fail_code_d = 2'd3;
                        pass_d      = 1'b0;
                    end else begin
                        fail_code_d = fail_code_q;
                        pass_d      = (fail_code_q == 2'd0);
                    end
                end else begin
                    chk_ptr_d = chk_ptr_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN) || (state_d == S_CHECK);
        done_d = (state_d == S_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            for (int r = 0; r < 32; r++) begin
                shadow_q[r] <= {XLEN{1'b0}};
            end
            tbl_en_q    <= {NUM_CHECKS{1'b0}};
            for (int i = 0; i < NUM_CHECKS; i++) begin
                tbl_reg_q[i] <= 5'd0;
                tbl_val_q[i] <= {XLEN{1'b0}};
            end
            chk_ptr_q   <= {IDX_W{1'b0}};
            mismatch_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_code_q <= 2'd0;
            fail_idx_q  <= {IDX_W{1'b0}};
            halt_code_q <= {XLEN{1'b0}};
            cycle_q     <= {CNT_W{1'b0}};
            retire_q    <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            tbl_en_q    <= tbl_en_d;
            tbl_reg_q   <= tbl_reg_d;
            tbl_val_q   <= tbl_val_d;
            chk_ptr_q   <= chk_ptr_d;
            mismatch_q  <= mismatch_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_code_q <= fail_code_d;
            fail_idx_q  <= fail_idx_d;
            halt_code_q <= halt_code_d;
            cycle_q     <= cycle_d;
            retire_q    <= retire_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign fail_code    = fail_code_q;
    assign fail_idx     = fail_idx_q;
    assign halt_code    = halt_code_q;
    assign cycle_count  = cycle_q;
    assign retire_count = retire_q;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Scoreboard bench for riscv_test_monitor: each terminating stimulus pushes
// its expected verdict; a monitor pops and compares on every rising done.
module tb_riscv_test_monitor;

    localparam int NC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start, wb_valid, st_valid, chk_we, chk_en;
    logic [4:0]  wb_rd, chk_reg;
    logic [31:0] wb_data, st_addr, st_data, chk_val;
    logic [1:0]  chk_idx;
    logic        busy, done, pass;
    logic [1:0]  fail_code, fail_idx;
    logic [31:0] halt_code, cycle_count, retire_count;

    typedef struct {
        logic        pass;
        logic [1:0]  fc;
        logic [1:0]  fidx;
        logic [31:0] halt;
        logic [31:0] cyc;
        logic [31:0] ret;
        int          done_at;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   last_start = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    riscv_test_monitor dut (
        .clk(clk), .rst(rst), .start(start),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
        .chk_we(chk_we), .chk_idx(chk_idx), .chk_en(chk_en),
        .chk_reg(chk_reg), .chk_val(chk_val),
        .busy(busy), .done(done), .pass(pass),
        .fail_code(fail_code), .fail_idx(fail_idx), .halt_code(halt_code),
        .cycle_count(cycle_count), .retire_count(retire_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_all();
        start = 1'b0; chk_we = 1'b0; chk_idx = 2'd0; chk_en = 1'b0;
        chk_reg = 5'd0; chk_val = 32'd0; wb_valid = 1'b0; wb_rd = 5'd0;
        wb_data = 32'd0; st_valid = 1'b0; st_addr = 32'd0; st_data = 32'd0;
    endtask

    task automatic tick();
        @(negedge clk);
        clear_all();
    endtask

    task automatic load(input logic [1:0] idx, input logic en, input logic [4:0] rg, input logic [31:0] val);
        tick();
        chk_we = 1'b1; chk_idx = idx; chk_en = en; chk_reg = rg; chk_val = val;
    endtask

    task automatic go();
        tick();
        start = 1'b1;
        last_start = cyc + 1;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] d);
        tick();
        wb_valid = 1'b1; wb_rd = rd; wb_data = d;
    endtask

    task automatic push(input logic p, input logic [1:0] fc, input logic [1:0] fi,
                        input logic [31:0] h, input logic [31:0] c, input logic [31:0] r, input int at);
        exp_t e;
        e.pass = p; e.fc = fc; e.fidx = fi; e.halt = h; e.cyc = c; e.ret = r; e.done_at = at;
        sb.push_back(e);
    endtask

    // Tohost store (optionally with a same-cycle writeback); done is due NC edges later.
    task automatic term(input logic [31:0] sd, input logic wv, input logic [4:0] rd, input logic [31:0] wd,
                        input bit expect_done, input logic p, input logic [1:0] fc, input logic [1:0] fi,
                        input logic [31:0] c, input logic [31:0] r);
        tick();
        st_valid = 1'b1; st_addr = 32'h0000_0FFC; st_data = sd;
        wb_valid = wv; wb_rd = rd; wb_data = wd;
        if (expect_done) push(p, fc, fi, sd, c, r, cyc + 1 + NC);
    endtask

    task automatic wait_sb();
        for (int i = 0; i < 400 && sb.size() != 0; i++) tick();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL done_wait actual=%0d pending expected=0 pending", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: compare every rising edge of done against the scoreboard head.
    initial begin
        exp_t e;
        logic dp;
        dp = 1'b0;
        forever begin
            @(negedge clk);
            if (done && !dp) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    check("pass",         {31'd0, pass},      {31'd0, e.pass});
                    check("fail_code",    {30'd0, fail_code}, {30'd0, e.fc});
                    check("fail_idx",     {30'd0, fail_idx},  {30'd0, e.fidx});
                    check("halt_code",    halt_code,          e.halt);
                    check("cycle_count",  cycle_count,        e.cyc);
                    check("retire_count", retire_count,       e.ret);
                    check("done_latency", cyc,                e.done_at);
                    check("busy_in_done", {31'd0, busy},      32'd0);
                end
            end
            dp = done;
        end
    end

    initial begin
        clear_all();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy",   {31'd0, busy}, 32'd0);
        check("rst_done",   {31'd0, done}, 32'd0);
        check("rst_pass",   {31'd0, pass}, 32'd0);
        check("rst_fcode",  {30'd0, fail_code}, 32'd0);
        check("rst_halt",   halt_code, 32'd0);
        check("rst_cycles", cycle_count, 32'd0);

        // 1: x10=89 expected, tohost=1 -> pass
        load(2'd0, 1'b1, 5'd10, 32'd89);
        go();
        wb(5'd10, 32'd89);
        term(32'd1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 2'd0, 2'd0, 32'd2, 32'd1);
        wait_sb();

        // 2: second entry mismatches (x11=8 vs 7)
        load(2'd0, 1'b1, 5'd10, 32'd15);
        load(2'd1, 1'b1, 5'd11, 32'd7);
        go();
        wb(5'd10, 32'd15);
        wb(5'd11, 32'd8);
        term(32'd1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 2'd3, 2'd1, 32'd2 + 32'd1, 32'd2);
        wait_sb();

        // 3a: timeout with no writebacks; entry0 also mismatches but timeout wins
        go();
        push(1'b0, 2'd1, 2'd0, 32'd0, 32'd200, 32'd0, last_start + 200 + NC);
        wait_sb();

        // 3b: timeout with a writeback every cycle
        go();
        push(1'b0, 2'd1, 2'd0, 32'd0, 32'd200, 32'd200, last_start + 200 + NC);
        for (int i = 0; i < 205; i++) wb(5'd5, i);
        wait_sb();

        // 4a: tohost code 3 with same-cycle writeback that satisfies entry0
        load(2'd0, 1'b1, 5'd10, 32'h0000_00FF);
        load(2'd1, 1'b0, 5'd11, 32'd7);
        go();
        term(32'd3, 1'b1, 5'd10, 32'h0000_00FF, 1'b1, 1'b0, 2'd2, 2'd0, 32'd1, 32'd1);
        wait_sb();

        // 4b: tohost lands on the timeout edge -> store wins, no timeout
        go();
        repeat (199) tick();
        term(32'd1, 1'b1, 5'd10, 32'h0000_00FF, 1'b1, 1'b1, 2'd0, 2'd0, 32'd200, 32'd1);
        wait_sb();

        // 5: x0 stays zero; table write and start during RUN are ignored
        load(2'd0, 1'b1, 5'd0, 32'd0);
        go();
        wb(5'd0, 32'd5);
        load(2'd1, 1'b1, 5'd12, 32'h0000_1234);
        tick();
        start = 1'b1;
        term(32'd1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 2'd0, 2'd0, 32'd4, 32'd1);
        wait_sb();
        check("done_hold_cycles", cycle_count, 32'd4);
        check("done_hold_level",  {31'd0, done}, 32'd1);
        go();
        tick();
        check("restart_cycles", cycle_count, 32'd0);
        check("restart_retire", retire_count, 32'd0);
        check("restart_busy",   {31'd0, busy}, 32'd1);
        check("restart_done",   {31'd0, done}, 32'd0);
        term(32'd1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 2'd0, 2'd0, 32'd2, 32'd0);
        wait_sb();

        // 6: reset mid-CHECK clears everything including the table
        load(2'd0, 1'b1, 5'd10, 32'd1);
        go();
        term(32'd1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 2'd0, 2'd0, 32'd0, 32'd0);
        tick();
        check("check_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy",   {31'd0, busy}, 32'd0);
        check("mid_rst_done",   {31'd0, done}, 32'd0);
        check("mid_rst_halt",   halt_code, 32'd0);
        check("mid_rst_cycles", cycle_count, 32'd0);
        go();
        term(32'd1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 2'd0, 2'd0, 32'd1, 32'd0);
        wait_sb();

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
